// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM states and stall-request levels.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    localparam logic MD_STALL   = 1'b1;
    localparam logic MD_NOSTALL = 1'b0;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_div};
    // i_rem < i_div always holds, so the subtraction borrows exactly when the divisor does not fit.
    assign o_q       = ~w_diff[WIDTH];
    assign o_rem     = o_q ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative mult/multu/div/divu unit for the EX stage, producing HI/LO and a stall request.
// Defining MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-cycle multiply.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             stallreq_o
);
    function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    md_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_sgn1, r_sgn2;
    logic [WIDTH-1:0]   r_opd, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_start, w_abort, w_last, w_div0, w_sin;
    logic [WIDTH-1:0]   w_mag1, w_mag2, w_rem_nxt;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_acc, w_acc_nxt, w_res;
    logic               w_is_div, w_signed, w_neg_prod, w_neg_rem;

    assign w_sin   = ~op_i[0];
    assign w_mag1  = f_cneg_w(opdata1_i, w_sin & opdata1_i[WIDTH-1]);
    assign w_mag2  = f_cneg_w(opdata2_i, w_sin & opdata2_i[WIDTH-1]);
    assign w_start = op_valid_i & ~annul_i;
    assign w_abort = annul_i | ~op_valid_i;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div0  = op_i[1] & (opdata2_i == '0);

    // r_acc holds {partial remainder, dividend/quotient} for divide, {product hi, multiplier/product lo} for multiply.
    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit (r_acc[WIDTH-1]),
        .i_div (r_opd),
        .o_rem (w_rem_nxt),
        .o_q   (w_qbit)
    );
    assign w_div_acc = {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = f_cneg_2w({{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2},
                                   w_sin & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]));
    assign w_acc_nxt   = w_div_acc;
`else
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_acc_nxt = (r_state == ST_DIV) ? w_div_acc : {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    assign w_is_div   = (r_op == MD_DIV) || (r_op == MD_DIVU);
    assign w_signed   = (r_op == MD_MULT) || (r_op == MD_DIV);
    assign w_neg_prod = w_signed & (r_sgn1 ^ r_sgn2);
    assign w_neg_rem  = w_signed & r_sgn1;
    assign w_res      = w_is_div ? {f_cneg_w(w_acc_nxt[2*WIDTH-1:WIDTH], w_neg_rem),
                                    f_cneg_w(w_acc_nxt[WIDTH-1:0], w_neg_prod)}
                                 : f_cneg_2w(w_acc_nxt, w_neg_prod);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (op_i[1])
                        w_state_nxt = w_div0 ? ST_DONE : ST_DIV;
`ifdef MULDIV_FAST_MUL_EN
                    else
                        w_state_nxt = ST_DONE;
`else
                    else
                        w_state_nxt = ST_MUL;
`endif
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_abort)
                    w_state_nxt = ST_IDLE;
                else if (w_last)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (annul_i || advance_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_sgn1 <= 1'b0;
            r_sgn2 <= 1'b0;
            r_opd  <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_start) begin
                r_cnt  <= '0;
                r_op   <= op_i;
                r_sgn1 <= opdata1_i[WIDTH-1];
                r_sgn2 <= opdata2_i[WIDTH-1];
                r_opd  <= op_i[1] ? w_mag2 : w_mag1;
                r_acc  <= {{WIDTH{1'b0}}, (op_i[1] ? w_mag1 : w_mag2)};
                if (w_div0) begin
                    r_hi <= opdata1_i;
                    r_lo <= '1;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!op_i[1]) begin
                    {r_hi, r_lo} <= w_fast_prod;
                end
`endif
            end
        end else if ((r_state == ST_MUL || r_state == ST_DIV) && !w_abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_nxt;
            if (w_last)
                {r_hi, r_lo} <= w_res;
        end
    end

    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign ready_o    = (r_state == ST_DONE);
    assign busy_o     = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign stallreq_o = (~rst & op_valid_i & ~annul_i & (r_state != ST_DONE)) ? MD_STALL : MD_NOSTALL;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO queued at issue, popped when ready_o rises.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid_i;
    logic [1:0]   op_i;
    logic [W-1:0] opdata1_i, opdata2_i;
    logic         annul_i, advance_i;
    logic [W-1:0] hi_o, lo_o;
    logic         ready_o, busy_o, stallreq_o;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .advance_i  (advance_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
    typedef struct { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] hi; logic [W-1:0] lo; } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, q, r;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'b10: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {r[W-1:0], q[W-1:0]};
            end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op[1]) return (b == '0) ? 1 : W + 1;
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return W + 1;
`endif
    endfunction

    // Drives an op starting just after a rising edge; returns at the falling edge of the first ready cycle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int stalls);
        op_valid_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        annul_i = 1'b0; advance_i = 1'b0;
        lat = 0; stalls = 0;
        while (lat <= 200) begin
            @(negedge clk);
            if (ready_o === 1'b1) break;
            if (stallreq_o === 1'b1) stalls++;
            lat++;
        end
    endtask

    task automatic release_done(input bit keep_valid);
        advance_i = 1'b1;
        if (!keep_valid) op_valid_i = 1'b0;
        @(posedge clk); #1;
        advance_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0;
        annul_i = 1'b0; advance_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (hi_o !== '0) begin n_fail++; $display("FAIL reset hi_o: got %h want 0", hi_o); end
        n_checks++; if (lo_o !== '0) begin n_fail++; $display("FAIL reset lo_o: got %h want 0", lo_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset ready_o: got %b want 0", ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy_o: got %b want 0", busy_o); end
        n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL reset stallreq_o: got %b want 0", stallreq_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        vec_t v[3];
        exp_t e;
        int lat, stalls;
        v[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        v[1] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        v[2] = '{2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};
        foreach (v[i]) begin
            sb_q.push_back('{v[i].hi, v[i].lo});
            do_op(v[i].op, v[i].a, v[i].b, lat, stalls);
            e = sb_q.pop_front();
            n_checks++; if (hi_o !== e.hi) begin n_fail++; $display("FAIL mul[%0d] hi: got %h want %h", i, hi_o, e.hi); end
            n_checks++; if (lo_o !== e.lo) begin n_fail++; $display("FAIL mul[%0d] lo: got %h want %h", i, lo_o, e.lo); end
            n_checks++; if (lat !== exp_lat(v[i].op, v[i].b)) begin n_fail++; $display("FAIL mul[%0d] ready cycle: got c%0d want c%0d", i, lat, exp_lat(v[i].op, v[i].b)); end
            n_checks++; if (stalls !== exp_lat(v[i].op, v[i].b)) begin n_fail++; $display("FAIL mul[%0d] stall cycles: got %0d want %0d", i, stalls, exp_lat(v[i].op, v[i].b)); end
            release_done(1'b0);
        end
    endtask

    task automatic test_div();
        vec_t v[4];
        exp_t e;
        int lat, stalls;
        v[0] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        v[1] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[2] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[3] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        foreach (v[i]) begin
            sb_q.push_back('{v[i].hi, v[i].lo});
            do_op(v[i].op, v[i].a, v[i].b, lat, stalls);
            e = sb_q.pop_front();
            n_checks++; if (hi_o !== e.hi) begin n_fail++; $display("FAIL div[%0d] hi: got %h want %h", i, hi_o, e.hi); end
            n_checks++; if (lo_o !== e.lo) begin n_fail++; $display("FAIL div[%0d] lo: got %h want %h", i, lo_o, e.lo); end
            n_checks++; if (lat !== exp_lat(v[i].op, v[i].b)) begin n_fail++; $display("FAIL div[%0d] ready cycle: got c%0d want c%0d", i, lat, exp_lat(v[i].op, v[i].b)); end
            n_checks++; if (stalls !== exp_lat(v[i].op, v[i].b)) begin n_fail++; $display("FAIL div[%0d] stall cycles: got %0d want %0d", i, stalls, exp_lat(v[i].op, v[i].b)); end
            release_done(1'b0);
        end
    endtask

    // Previous result is div 5/0: hi=5, lo=all ones.
    task automatic test_annul();
        exp_t e;
        int lat, stalls;
        op_valid_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL annul busy at c10: got %b want 1", busy_o); end
        annul_i = 1'b1;
        #1;
        n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL annul stallreq: got %b want 0", stallreq_o); end
        @(posedge clk); #1;
        annul_i = 1'b0; op_valid_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL annul busy after: got %b want 0", busy_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL annul ready[%0d]: got %b want 0", k, ready_o); end
            n_checks++; if ({hi_o, lo_o} !== {32'h0000_0005, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL annul hilo[%0d]: got %h_%h want 00000005_ffffffff", k, hi_o, lo_o); end
        end
        @(posedge clk); #1;
        sb_q.push_back('{32'd2, 32'd14});
        do_op(2'b11, 32'd100, 32'd7, lat, stalls);
        e = sb_q.pop_front();
        n_checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL reissue divu hilo: got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo); end
        n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL reissue divu ready cycle: got c%0d want c%0d", lat, W + 1); end
    endtask

    // Entered at the falling edge of the first DONE cycle of divu 100/7, op_valid_i still high.
    task automatic test_hold();
        exp_t e;
        int lat, stalls;
        logic [2*W-1:0] m;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL hold ready[%0d]: got %b want 1", k, ready_o); end
            n_checks++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL hold hilo[%0d]: got %h_%h want 00000002_0000000e", k, hi_o, lo_o); end
            n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL hold stallreq[%0d]: got %b want 0", k, stallreq_o); end
            @(negedge clk);
        end
        op_i = 2'b00; opdata1_i = 32'h1234_5678; opdata2_i = 32'hFEDC_BA98;
        release_done(1'b1);
        m = model(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
        sb_q.push_back('{m[2*W-1:W], m[W-1:0]});
        do_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, lat, stalls);
        e = sb_q.pop_front();
        n_checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL b2b mult hilo: got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo); end
        n_checks++; if (lat !== exp_lat(2'b00, 32'hFEDC_BA98)) begin n_fail++; $display("FAIL b2b mult ready cycle: got c%0d want c%0d", lat, exp_lat(2'b00, 32'hFEDC_BA98)); end
        release_done(1'b0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat, stalls;
        op_valid_i = 1'b1; annul_i = 1'b0; advance_i = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        op_i = 2'b11;
`else
        op_i = 2'b00;
`endif
        opdata1_i = 32'h0000_1234; opdata2_i = 32'h0000_0056;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (hi_o !== '0) begin n_fail++; $display("FAIL midreset hi_o: got %h want 0", hi_o); end
        n_checks++; if (lo_o !== '0) begin n_fail++; $display("FAIL midreset lo_o: got %h want 0", lo_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL midreset ready_o: got %b want 0", ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset busy_o: got %b want 0", busy_o); end
        n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL midreset stallreq_o: got %b want 0", stallreq_o); end
        op_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb_q.push_back('{32'd2, 32'd14});
        do_op(2'b11, 32'd100, 32'd7, lat, stalls);
        e = sb_q.pop_front();
        n_checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL post-reset divu hilo: got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo); end
        release_done(1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, stalls;
        logic [1:0] op;
        logic [W-1:0] a, b;
        logic [2*W-1:0] m;
        for (int k = 0; k < 8; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (k == 3) ? '0 : ((k % 2) == 1) ? W'($urandom_range(1, 20)) : $urandom;
            m  = model(op, a, b);
            sb_q.push_back('{m[2*W-1:W], m[W-1:0]});
            do_op(op, a, b, lat, stalls);
            e = sb_q.pop_front();
            n_checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", k, op, a, b, hi_o, lo_o, e.hi, e.lo); end
            n_checks++; if (lat !== exp_lat(op, b)) begin n_fail++; $display("FAIL rand[%0d] ready cycle: got c%0d want c%0d", k, lat, exp_lat(op, b)); end
            release_done(k != 7);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_annul();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
